dbg_guv_mc: RTL and testbench
=============================

// Module: dbg_guv_mc
// PURPOSE
//  N_CHAN-channel debug governor: one command-chain address gates several AXI streams.
//  Each channel can be paused, can drop flits, and can log flits.
//  Logged flits from all channels merge round-robin onto one channel-tagged log stream.
//  Sits in the daisy-chained cmd_in->cmd_out debug chain, between producer and consumer.
// PARAMETERS
//  DATA_WIDTH   64  stream and command word width (>= ADDR_WIDTH+CHAN_BITS+4+32)
//  DEST_WIDTH   16  TDEST width per channel
//  ID_WIDTH     16  TID width per channel
//  N_CHAN       4   number of governed channels (1..16); CHAN_BITS = max(1,clog2(N_CHAN))
//  CNT_SIZE     16  drop/log counter width (<= 32)
//  ADDR_WIDTH   11  command address field width
//  ADDR         0   this block's chain address
//  STICKY_MODE  1   1: LATCH keeps shadow regs; 0: LATCH clears shadow regs to 0
//  PIPE_STAGE   0   1: cmd_out registered (+1 cycle); 0: combinational
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous reset, active-high
//  cmd_in_TDATA    in   DATA_WIDTH command word; no TREADY (never backpressures)
//  cmd_in_TVALID   in   1          command valid
//  cmd_out_TDATA   out  DATA_WIDTH forwarded command
//  cmd_out_TVALID  out  1          forwarded command valid
//  din_T{DATA,KEEP,DEST,ID,LAST,VALID}  in   N_CHAN*field  packed; channel c at [c*W +: W]
//  din_TREADY      out  N_CHAN     per-channel ready
//  dout_T{DATA,KEEP,DEST,ID,LAST,VALID} out  N_CHAN*field  packed as din
//  dout_TREADY     in   N_CHAN     per-channel ready
//  log_TDATA       out  CHAN_BITS+DATA_WIDTH/8+DATA_WIDTH  {chan, TKEEP, TDATA}
//  log_TVALID/TLAST out 1          log valid / copied TLAST
//  log_TREADY      in   1          log ready
// BEHAVIOUR
//  Cmd fields: addr=[DW-1 -: ADDR_WIDTH], chan=[36 +: CHAN_BITS], reg=[35:32], val=[CNT_SIZE-1:0].
//  addr==ADDR: command consumed and not forwarded; otherwise copied to cmd_out (PIPE_STAGE delay).
//  chan>=N_CHAN, or reg not in 0..5: command consumed, ignored.
//  Regs 0..4 write per-channel shadow: 0 PAUSE, 1 KEEP_DROP, 2 KEEP_LOG (val[0]), 3 DROP_CNT, 4 LOG_CNT.
//  Reg 5 LATCH copies that channel's shadow into the active regs.
//  Active regs are visible on the cycle after LATCH is sampled.
//  Per channel c, drop = KEEP_DROP | (drop_cnt!=0), log = KEEP_LOG | (log_cnt!=0):
//   PAUSE: din_TREADY=0, dout_TVALID=0.
//   Otherwise the fork is combinational, no added latency. Flit xfer requires din_TVALID
//   and (drop | dout_TREADY) and (!log | logbuf empty).
//   dout_TVALID = din_TVALID & !drop & (!log | logbuf empty). din_TREADY = same condition set.
//   On xfer: if drop and drop_cnt!=0, drop_cnt-1; if log, flit enters logbuf; if log_cnt!=0, log_cnt-1.
//   Counters saturate at 0 (no wrap). LATCH in same cycle as xfer: LATCH value wins.
//  Logbuf: 1 entry per channel {KEEP,DATA,LAST}; filled on logged xfer, emptied on log grant handshake.
//  Log arbiter: round-robin from ptr.
//   Grant = first non-empty logbuf at or after ptr. Grant is locked while log_TVALID & !log_TREADY.
//   On handshake, ptr = grant+1 (mod N_CHAN). The freed logbuf can refill the next cycle.
//  Reset (any time): all shadow/active regs 0, logbufs empty, ptr 0, pipe reg cleared.
//   Outputs after reset: cmd_out_TVALID=0, log_TVALID=0, din_TREADY=dout_TREADY passthrough (unpaused).
//   In-flight log entries are discarded.
// TESTING
//  Reset, no commands: ch0 din stream 0,2,4.. with dout_TREADY=1 -> identical dout, log_TVALID never 1.
//  Cmd addr=ADDR+1 -> consumed=0, appears on cmd_out next cycle (PIPE_STAGE=1) or same cycle (0).
//  ch1 DROP_CNT=3, LATCH -> first 3 ch1 flits accepted not forwarded, 4th forwarded; ch0 unaffected.
//  ch0,ch2 LOG_CNT=2, log_TREADY toggling -> 4 log flits, chan tags alternate 0,2,0,2, data intact.
//  ch3 PAUSE=1, LATCH -> din_TREADY[3]=0 forever; PAUSE=0, LATCH -> flow resumes next cycle.
//  rst pulse with full logbufs -> log_TVALID=0 next cycle, all counters 0, STICKY_MODE=0 clears shadow.

Source files
------------

// File: rtl/dbg_guv_mc.sv
// ---------------------------------------------------------------------------
// dbg_guv_mc
//
// Multi-channel debug governor. One address on the daisy-chained command bus
// controls N_CHAN AXI streams. Each stream can be paused, can have flits
// dropped (permanently or for a counted number of flits), and can have flits
// copied into a single-entry log buffer. The log buffers of all channels are
// merged round-robin onto one log stream tagged with the channel number.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_in_T{DATA,VALID}          command chain input (never backpressured)
//   cmd_out_T{DATA,VALID}         commands for other addresses, forwarded
//   din_T{DATA,KEEP,DEST,ID,LAST,VALID}, din_TREADY
//                                 producer side, N_CHAN channels packed
//   dout_T{DATA,KEEP,DEST,ID,LAST,VALID}, dout_TREADY
//                                 consumer side, packed like din
//   log_T{DATA,VALID,LAST}, log_TREADY
//                                 merged log stream, TDATA = {chan, KEEP, DATA}
// ---------------------------------------------------------------------------
module dbg_guv_mc #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 16,
    parameter int ID_WIDTH    = 16,
    parameter int N_CHAN      = 4,
    parameter int CNT_SIZE    = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int ADDR        = 0,
    parameter int STICKY_MODE = 1,
    parameter int PIPE_STAGE  = 0,
    localparam int CHAN_BITS  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int LOG_WIDTH  = CHAN_BITS + KEEP_WIDTH + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [DATA_WIDTH-1:0]          cmd_in_TDATA,
    input  logic                           cmd_in_TVALID,
    output logic [DATA_WIDTH-1:0]          cmd_out_TDATA,
    output logic                           cmd_out_TVALID,

    input  logic [N_CHAN*DATA_WIDTH-1:0]   din_TDATA,
    input  logic [N_CHAN*KEEP_WIDTH-1:0]   din_TKEEP,
    input  logic [N_CHAN*DEST_WIDTH-1:0]   din_TDEST,
    input  logic [N_CHAN*ID_WIDTH-1:0]     din_TID,
    input  logic [N_CHAN-1:0]              din_TLAST,
    input  logic [N_CHAN-1:0]              din_TVALID,
    output logic [N_CHAN-1:0]              din_TREADY,

    output logic [N_CHAN*DATA_WIDTH-1:0]   dout_TDATA,
    output logic [N_CHAN*KEEP_WIDTH-1:0]   dout_TKEEP,
    output logic [N_CHAN*DEST_WIDTH-1:0]   dout_TDEST,
    output logic [N_CHAN*ID_WIDTH-1:0]     dout_TID,
    output logic [N_CHAN-1:0]              dout_TLAST,
    output logic [N_CHAN-1:0]              dout_TVALID,
    input  logic [N_CHAN-1:0]              dout_TREADY,

    output logic [LOG_WIDTH-1:0]           log_TDATA,
    output logic                           log_TVALID,
    output logic                           log_TLAST,
    input  logic                           log_TREADY
);

    localparam logic [3:0] REG_PAUSE     = 4'd0;
    localparam logic [3:0] REG_KEEP_DROP = 4'd1;
    localparam logic [3:0] REG_KEEP_LOG  = 4'd2;
    localparam logic [3:0] REG_DROP_CNT  = 4'd3;
    localparam logic [3:0] REG_LOG_CNT   = 4'd4;
    localparam logic [3:0] REG_LATCH     = 4'd5;

    // Shadow registers (written by commands) and active registers (used by the fork)
    logic [N_CHAN-1:0]                sh_pause_q, sh_pause_d;
    logic [N_CHAN-1:0]                sh_keep_drop_q, sh_keep_drop_d;
    logic [N_CHAN-1:0]                sh_keep_log_q, sh_keep_log_d;
    logic [N_CHAN-1:0][CNT_SIZE-1:0]  sh_drop_cnt_q, sh_drop_cnt_d;
    logic [N_CHAN-1:0][CNT_SIZE-1:0]  sh_log_cnt_q, sh_log_cnt_d;

    logic [N_CHAN-1:0]                act_pause_q, act_pause_d;
    logic [N_CHAN-1:0]                act_keep_drop_q, act_keep_drop_d;
    logic [N_CHAN-1:0]                act_keep_log_q, act_keep_log_d;
    logic [N_CHAN-1:0][CNT_SIZE-1:0]  act_drop_cnt_q, act_drop_cnt_d;
    logic [N_CHAN-1:0][CNT_SIZE-1:0]  act_log_cnt_q, act_log_cnt_d;

    // One log buffer entry per channel
    logic [N_CHAN-1:0]                  lb_valid_q, lb_valid_d;
    logic [N_CHAN-1:0]                  lb_last_q, lb_last_d;
    logic [N_CHAN-1:0][DATA_WIDTH-1:0]  lb_data_q, lb_data_d;
    logic [N_CHAN-1:0][KEEP_WIDTH-1:0]  lb_keep_q, lb_keep_d;

    // Round-robin pointer plus a hold so an offered log flit cannot change
    // channel while the consumer is stalling it
    logic [CHAN_BITS-1:0]  ptr_q, ptr_d;
    logic                  hold_q, hold_d;
    logic [CHAN_BITS-1:0]  hold_chan_q, hold_chan_d;

    logic                   cmd_pipe_valid_q, cmd_pipe_valid_d;
    logic [DATA_WIDTH-1:0]  cmd_pipe_data_q, cmd_pipe_data_d;

    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [CHAN_BITS-1:0]   cmd_chan;
    logic [3:0]             cmd_reg;
    logic [CNT_SIZE-1:0]    cmd_val;
    logic                   cmd_addr_match;
    logic                   cmd_hit;
    logic                   cmd_fwd;

    logic [N_CHAN-1:0]      drop;
    logic [N_CHAN-1:0]      logging;
    logic [N_CHAN-1:0]      lb_room;
    logic [N_CHAN-1:0]      in_ready;
    logic [N_CHAN-1:0]      xfer;

    logic                   gnt_found;
    logic [CHAN_BITS-1:0]   gnt_chan;
    logic [CHAN_BITS-1:0]   cand;
    logic                   log_hs;

    assign cmd_addr       = cmd_in_TDATA[DATA_WIDTH-1 -: ADDR_WIDTH];
    assign cmd_chan       = cmd_in_TDATA[36 +: CHAN_BITS];
    assign cmd_reg        = cmd_in_TDATA[35:32];
    assign cmd_val        = cmd_in_TDATA[CNT_SIZE-1:0];
    assign cmd_addr_match = (cmd_addr == ADDR_WIDTH'(ADDR));
    assign cmd_hit        = cmd_in_TVALID && cmd_addr_match && (int'(cmd_chan) < N_CHAN);
    assign cmd_fwd        = cmd_in_TVALID && !cmd_addr_match;

    assign cmd_out_TVALID = (PIPE_STAGE != 0) ? cmd_pipe_valid_q : cmd_fwd;
    assign cmd_out_TDATA  = (PIPE_STAGE != 0) ? cmd_pipe_data_q  : cmd_in_TDATA;

    // Payload always passes straight through; only the handshake is governed
    assign dout_TDATA = din_TDATA;
    assign dout_TKEEP = din_TKEEP;
    assign dout_TDEST = din_TDEST;
    assign dout_TID   = din_TID;
    assign dout_TLAST = din_TLAST;
    assign din_TREADY = in_ready;

    // Per-channel fork. A logging channel stalls while its log buffer is
    // still occupied, so a logged flit can never be lost.
    always_comb begin
        drop        = '0;
        logging     = '0;
        lb_room     = '0;
        in_ready    = '0;
        xfer        = '0;
        dout_TVALID = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            drop[c]        = act_keep_drop_q[c] | (act_drop_cnt_q[c] != '0);
            logging[c]     = act_keep_log_q[c] | (act_log_cnt_q[c] != '0);
            lb_room[c]     = !logging[c] | !lb_valid_q[c];
            in_ready[c]    = !act_pause_q[c] & (drop[c] | dout_TREADY[c]) & lb_room[c];
            dout_TVALID[c] = !act_pause_q[c] & din_TVALID[c] & !drop[c] & lb_room[c];
            xfer[c]        = din_TVALID[c] & in_ready[c];
        end
    end

    // Log arbiter: first occupied buffer at or after ptr, unless a stalled
    // grant is being held
    always_comb begin
        gnt_found = 1'b0;
        gnt_chan  = '0;
        cand      = '0;
        if (hold_q) begin
            gnt_found = 1'b1;
            gnt_chan  = hold_chan_q;
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                cand = CHAN_BITS'((int'(ptr_q) + k) % N_CHAN);
                if (!gnt_found && lb_valid_q[cand]) begin
                    gnt_found = 1'b1;
                    gnt_chan  = cand;
                end
            end
        end
    end

    assign log_TVALID = gnt_found;
    assign log_TDATA  = {gnt_chan, lb_keep_q[gnt_chan], lb_data_q[gnt_chan]};
    assign log_TLAST  = lb_last_q[gnt_chan];
    assign log_hs     = gnt_found & log_TREADY;

    // Next-state: counters, log buffers, arbiter and command handling.
    // Commands are applied after the transfer updates so a LATCH in the same
    // cycle as a transfer overrides the decremented counters.
    always_comb begin
        sh_pause_d       = sh_pause_q;
        sh_keep_drop_d   = sh_keep_drop_q;
        sh_keep_log_d    = sh_keep_log_q;
        sh_drop_cnt_d    = sh_drop_cnt_q;
        sh_log_cnt_d     = sh_log_cnt_q;
        act_pause_d      = act_pause_q;
        act_keep_drop_d  = act_keep_drop_q;
        act_keep_log_d   = act_keep_log_q;
        act_drop_cnt_d   = act_drop_cnt_q;
        act_log_cnt_d    = act_log_cnt_q;
        lb_valid_d       = lb_valid_q;
        lb_last_d        = lb_last_q;
        lb_data_d        = lb_data_q;
        lb_keep_d        = lb_keep_q;
        ptr_d            = ptr_q;
        hold_d           = gnt_found & !log_TREADY;
        hold_chan_d      = gnt_chan;
        cmd_pipe_valid_d = cmd_fwd;
        cmd_pipe_data_d  = cmd_in_TDATA;

        for (int c = 0; c < N_CHAN; c++) begin
            if (xfer[c]) begin
                if (drop[c] && (act_drop_cnt_q[c] != '0)) begin
                    act_drop_cnt_d[c] = act_drop_cnt_q[c] - CNT_SIZE'(1);
                end
                if (act_log_cnt_q[c] != '0) begin
                    act_log_cnt_d[c] = act_log_cnt_q[c] - CNT_SIZE'(1);
                end
                if (logging[c]) begin
                    lb_valid_d[c] = 1'b1;
                    lb_data_d[c]  = din_TDATA[c*DATA_WIDTH +: DATA_WIDTH];
                    lb_keep_d[c]  = din_TKEEP[c*KEEP_WIDTH +: KEEP_WIDTH];
                    lb_last_d[c]  = din_TLAST[c];
                end
            end
        end

        if (log_hs) begin
            lb_valid_d[gnt_chan] = 1'b0;
            if (int'(gnt_chan) == N_CHAN - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_chan + CHAN_BITS'(1);
            end
        end

        if (cmd_hit) begin
            case (cmd_reg)
                REG_PAUSE:     sh_pause_d[cmd_chan]     = cmd_val[0];
                REG_KEEP_DROP: sh_keep_drop_d[cmd_chan] = cmd_val[0];
                REG_KEEP_LOG:  sh_keep_log_d[cmd_chan]  = cmd_val[0];
                REG_DROP_CNT:  sh_drop_cnt_d[cmd_chan]  = cmd_val;
                REG_LOG_CNT:   sh_log_cnt_d[cmd_chan]   = cmd_val;
                REG_LATCH: begin
                    act_pause_d[cmd_chan]     = sh_pause_q[cmd_chan];
                    act_keep_drop_d[cmd_chan] = sh_keep_drop_q[cmd_chan];
                    act_keep_log_d[cmd_chan]  = sh_keep_log_q[cmd_chan];
                    act_drop_cnt_d[cmd_chan]  = sh_drop_cnt_q[cmd_chan];
                    act_log_cnt_d[cmd_chan]   = sh_log_cnt_q[cmd_chan];
                    if (STICKY_MODE == 0) begin
                        sh_pause_d[cmd_chan]     = 1'b0;
                        sh_keep_drop_d[cmd_chan] = 1'b0;
                        sh_keep_log_d[cmd_chan]  = 1'b0;
                        sh_drop_cnt_d[cmd_chan]  = '0;
                        sh_log_cnt_d[cmd_chan]   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset discards any log entries still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pause_q       <= '0;
            sh_keep_drop_q   <= '0;
            sh_keep_log_q    <= '0;
            sh_drop_cnt_q    <= '0;
            sh_log_cnt_q     <= '0;
            act_pause_q      <= '0;
            act_keep_drop_q  <= '0;
            act_keep_log_q   <= '0;
            act_drop_cnt_q   <= '0;
            act_log_cnt_q    <= '0;
            lb_valid_q       <= '0;
            lb_last_q        <= '0;
            lb_data_q        <= '0;
            lb_keep_q        <= '0;
            ptr_q            <= '0;
            hold_q           <= 1'b0;
            hold_chan_q      <= '0;
            cmd_pipe_valid_q <= 1'b0;
            cmd_pipe_data_q  <= '0;
        end else begin
            sh_pause_q       <= sh_pause_d;
            sh_keep_drop_q   <= sh_keep_drop_d;
            sh_keep_log_q    <= sh_keep_log_d;
            sh_drop_cnt_q    <= sh_drop_cnt_d;
            sh_log_cnt_q     <= sh_log_cnt_d;
            act_pause_q      <= act_pause_d;
            act_keep_drop_q  <= act_keep_drop_d;
            act_keep_log_q   <= act_keep_log_d;
            act_drop_cnt_q   <= act_drop_cnt_d;
            act_log_cnt_q    <= act_log_cnt_d;
            lb_valid_q       <= lb_valid_d;
            lb_last_q        <= lb_last_d;
            lb_data_q        <= lb_data_d;
            lb_keep_q        <= lb_keep_d;
            ptr_q            <= ptr_d;
            hold_q           <= hold_d;
            hold_chan_q      <= hold_chan_d;
            cmd_pipe_valid_q <= cmd_pipe_valid_d;
            cmd_pipe_data_q  <= cmd_pipe_data_d;
        end
    end

endmodule

// File: tb/tb_dbg_guv_mc.sv
// ---------------------------------------------------------------------------
// tb_dbg_guv_mc
//
// Bench for dbg_guv_mc with default parameters (4 channels, ADDR 0,
// combinational command forwarding, sticky shadow registers). A reference
// model of channel settings, log buffers and the round-robin pointer runs
// alongside every clock; directed scenarios check against constants and a
// random traffic phase checks every output against the model.
// ---------------------------------------------------------------------------
module tb_dbg_guv_mc;

    localparam int DW     = 64;
    localparam int KW     = 8;
    localparam int N      = 4;
    localparam int CB     = 2;
    localparam int LOG_W  = CB + KW + DW;
    localparam int ADDR   = 0;
    localparam bit STICKY = 1'b1;

    logic               clk = 1'b0;
    logic               rst;
    logic [DW-1:0]      cmd_in_TDATA;
    logic               cmd_in_TVALID;
    logic [DW-1:0]      cmd_out_TDATA;
    logic               cmd_out_TVALID;
    logic [N*DW-1:0]    din_TDATA;
    logic [N*KW-1:0]    din_TKEEP;
    logic [N*16-1:0]    din_TDEST;
    logic [N*16-1:0]    din_TID;
    logic [N-1:0]       din_TLAST;
    logic [N-1:0]       din_TVALID;
    logic [N-1:0]       din_TREADY;
    logic [N*DW-1:0]    dout_TDATA;
    logic [N*KW-1:0]    dout_TKEEP;
    logic [N*16-1:0]    dout_TDEST;
    logic [N*16-1:0]    dout_TID;
    logic [N-1:0]       dout_TLAST;
    logic [N-1:0]       dout_TVALID;
    logic [N-1:0]       dout_TREADY;
    logic [LOG_W-1:0]   log_TDATA;
    logic               log_TVALID;
    logic               log_TLAST;
    logic               log_TREADY;

    int checks = 0;
    int errors = 0;

    dbg_guv_mc dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_in_TDATA   (cmd_in_TDATA),
        .cmd_in_TVALID  (cmd_in_TVALID),
        .cmd_out_TDATA  (cmd_out_TDATA),
        .cmd_out_TVALID (cmd_out_TVALID),
        .din_TDATA      (din_TDATA),
        .din_TKEEP      (din_TKEEP),
        .din_TDEST      (din_TDEST),
        .din_TID        (din_TID),
        .din_TLAST      (din_TLAST),
        .din_TVALID     (din_TVALID),
        .din_TREADY     (din_TREADY),
        .dout_TDATA     (dout_TDATA),
        .dout_TKEEP     (dout_TKEEP),
        .dout_TDEST     (dout_TDEST),
        .dout_TID       (dout_TID),
        .dout_TLAST     (dout_TLAST),
        .dout_TVALID    (dout_TVALID),
        .dout_TREADY    (dout_TREADY),
        .log_TDATA      (log_TDATA),
        .log_TVALID     (log_TVALID),
        .log_TLAST      (log_TLAST),
        .log_TREADY     (log_TREADY)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit            sh_pause[N], sh_kdrop[N], sh_klog[N];
    int            sh_dcnt[N], sh_lcnt[N];
    bit            ac_pause[N], ac_kdrop[N], ac_klog[N];
    int            ac_dcnt[N], ac_lcnt[N];
    bit            lb_full[N];
    logic [DW-1:0] lb_data[N];
    logic [KW-1:0] lb_keep[N];
    bit            lb_last[N];
    int            rr_ptr;
    int            pending;

    // Model view of the current cycle
    logic [N-1:0]  e_rdy, e_dv, e_xfer, e_drop, e_log;
    int            e_grant;
    bit            e_cmd_fwd;

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            sh_pause[c] = 0; sh_kdrop[c] = 0; sh_klog[c] = 0; sh_dcnt[c] = 0; sh_lcnt[c] = 0;
            ac_pause[c] = 0; ac_kdrop[c] = 0; ac_klog[c] = 0; ac_dcnt[c] = 0; ac_lcnt[c] = 0;
            lb_full[c] = 0; lb_data[c] = '0; lb_keep[c] = '0; lb_last[c] = 0;
        end
        rr_ptr  = 0;
        pending = -1;
    endfunction

    function automatic void model_eval();
        for (int c = 0; c < N; c++) begin
            bit dr, lg, room;
            dr   = ac_kdrop[c] || (ac_dcnt[c] > 0);
            lg   = ac_klog[c] || (ac_lcnt[c] > 0);
            room = !lg || !lb_full[c];
            e_drop[c] = dr;
            e_log[c]  = lg;
            e_rdy[c]  = !ac_pause[c] && (dr || dout_TREADY[c]) && room;
            e_dv[c]   = !ac_pause[c] && din_TVALID[c] && !dr && room;
            e_xfer[c] = din_TVALID[c] && e_rdy[c];
        end
        if (pending >= 0) begin
            e_grant = pending;
        end else begin
            e_grant = -1;
            for (int k = 0; k < N; k++) begin
                if (e_grant < 0 && lb_full[(rr_ptr + k) % N]) e_grant = (rr_ptr + k) % N;
            end
        end
        e_cmd_fwd = cmd_in_TVALID && (int'(cmd_in_TDATA[63:53]) != ADDR);
    endfunction

    function automatic void model_commit();
        int a, ch, rg, v;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            if (e_xfer[c]) begin
                if (e_drop[c] && ac_dcnt[c] > 0) ac_dcnt[c]--;
                if (ac_lcnt[c] > 0) ac_lcnt[c]--;
                if (e_log[c]) begin
                    lb_full[c] = 1;
                    lb_data[c] = din_TDATA[c*DW +: DW];
                    lb_keep[c] = din_TKEEP[c*KW +: KW];
                    lb_last[c] = din_TLAST[c];
                end
            end
        end
        if (e_grant >= 0) begin
            if (log_TREADY) begin
                lb_full[e_grant] = 0;
                rr_ptr  = (e_grant + 1) % N;
                pending = -1;
            end else begin
                pending = e_grant;
            end
        end else begin
            pending = -1;
        end
        a  = int'(cmd_in_TDATA[63:53]);
        ch = int'(cmd_in_TDATA[37:36]);
        rg = int'(cmd_in_TDATA[35:32]);
        v  = int'(cmd_in_TDATA[15:0]);
        if (cmd_in_TVALID && a == ADDR && ch < N) begin
            case (rg)
                0: sh_pause[ch] = v[0];
                1: sh_kdrop[ch] = v[0];
                2: sh_klog[ch]  = v[0];
                3: sh_dcnt[ch]  = v;
                4: sh_lcnt[ch]  = v;
                5: begin
                    ac_pause[ch] = sh_pause[ch]; ac_kdrop[ch] = sh_kdrop[ch];
                    ac_klog[ch]  = sh_klog[ch];  ac_dcnt[ch]  = sh_dcnt[ch];
                    ac_lcnt[ch]  = sh_lcnt[ch];
                    if (!STICKY) begin
                        sh_pause[ch] = 0; sh_kdrop[ch] = 0; sh_klog[ch] = 0;
                        sh_dcnt[ch] = 0; sh_lcnt[ch] = 0;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [DW-1:0] mk_cmd(int addr, int ch, int rg, int v);
        logic [DW-1:0] w;
        w = '0;
        w[63:53] = 11'(addr);
        w[37:36] = 2'(ch);
        w[35:32] = 4'(rg);
        w[15:0]  = 16'(v);
        return w;
    endfunction

    // Inputs are driven on the falling edge; outputs are sampled 1ns later
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic send_cmd(int addr, int ch, int rg, int v);
        cmd_in_TDATA  = mk_cmd(addr, ch, rg, v);
        cmd_in_TVALID = 1'b1;
        settle();
        tick();
        cmd_in_TVALID = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dout_TREADY = 4'($urandom);
            settle();
            checks++;
            if (din_TREADY !== dout_TREADY) begin
                errors++;
                $display("[TB] FAIL reset_ready: got %b expected %b", din_TREADY, dout_TREADY);
            end
            checks++;
            if (cmd_out_TVALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_out_TVALID);
            end
            checks++;
            if (log_TVALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_log_valid: got %b expected 0", log_TVALID);
            end
            tick();
        end
    endtask

    task automatic test_passthrough();
        dout_TREADY = '1;
        log_TREADY  = 1'b1;
        din_TVALID  = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            din_TDATA[63:0] = 64'(2 * i);
            settle();
            checks++;
            if (dout_TVALID[0] !== 1'b1 || dout_TDATA[63:0] !== 64'(2 * i)) begin
                errors++;
                $display("[TB] FAIL pass_data: got v=%b d=%0h expected v=1 d=%0h",
                         dout_TVALID[0], dout_TDATA[63:0], 2 * i);
            end
            checks++;
            if (log_TVALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pass_log_valid: got %b expected 0", log_TVALID);
            end
            tick();
        end
        din_TVALID = '0;
    endtask

    task automatic test_cmd_forward();
        logic [DW-1:0] w;
        w = mk_cmd(ADDR + 1, 1, 0, 16'h1234);
        cmd_in_TDATA  = w;
        cmd_in_TVALID = 1'b1;
        settle();
        checks++;
        if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== w) begin
            errors++;
            $display("[TB] FAIL cmd_forward: got v=%b d=%h expected v=1 d=%h",
                     cmd_out_TVALID, cmd_out_TDATA, w);
        end
        tick();
        cmd_in_TDATA = mk_cmd(ADDR, 2, 9, 16'h0001);
        settle();
        checks++;
        if (cmd_out_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cmd_consume: got %b expected 0", cmd_out_TVALID);
        end
        tick();
        cmd_in_TVALID = 1'b0;
    endtask

    task automatic test_drop_count();
        send_cmd(ADDR, 1, 3, 3);
        send_cmd(ADDR, 1, 5, 0);
        dout_TREADY = '1;
        din_TVALID  = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            din_TDATA[63:0]   = 64'(200 + i);
            din_TDATA[127:64] = 64'(100 + i);
            settle();
            checks++;
            if (din_TREADY[1] !== 1'b1 || dout_TVALID[1] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL drop_ch1 flit %0d: got rdy=%b v=%b expected rdy=1 v=%b",
                         i, din_TREADY[1], dout_TVALID[1], (i == 3));
            end
            checks++;
            if (dout_TVALID[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL drop_ch0 flit %0d: got %b expected 1", i, dout_TVALID[0]);
            end
            tick();
        end
        din_TVALID = '0;
    endtask

    task automatic test_log_rr();
        int idx0, idx2, got;
        int exp_tag[4];
        logic [63:0] exp_dat[4];
        exp_tag = '{0, 2, 0, 2};
        exp_dat = '{64'hA000, 64'hC000, 64'hA001, 64'hC001};
        send_cmd(ADDR, 0, 4, 2);
        send_cmd(ADDR, 2, 4, 2);
        send_cmd(ADDR, 0, 5, 0);
        send_cmd(ADDR, 2, 5, 0);
        idx0 = 0;
        idx2 = 0;
        got  = 0;
        dout_TREADY = '1;
        din_TKEEP   = '1;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            din_TVALID        = {1'b0, idx2 < 4, 1'b0, idx0 < 4};
            din_TDATA[63:0]   = 64'(32'hA000 + idx0);
            din_TDATA[191:128]= 64'(32'hC000 + idx2);
            din_TLAST[0]      = idx0[0];
            din_TLAST[2]      = 1'b1;
            log_TREADY        = cyc[0];
            settle();
            if (log_TVALID && log_TREADY) begin
                checks++;
                if (int'(log_TDATA[LOG_W-1 -: CB]) != exp_tag[got] ||
                    log_TDATA[63:0] !== exp_dat[got] || log_TDATA[DW +: KW] !== 8'hFF ||
                    log_TLAST !== (exp_tag[got] == 2 ? 1'b1 : exp_dat[got][0])) begin
                    errors++;
                    $display("[TB] FAIL log_rr flit %0d: got tag=%0d d=%h last=%b expected tag=%0d d=%h",
                             got, log_TDATA[LOG_W-1 -: CB], log_TDATA[63:0], log_TLAST,
                             exp_tag[got], exp_dat[got]);
                end
                got++;
            end
            if (din_TVALID[0] && din_TREADY[0]) idx0++;
            if (din_TVALID[2] && din_TREADY[2]) idx2++;
            tick();
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("[TB] FAIL log_rr_count: got %0d expected 4", got);
        end
        din_TVALID = 4'b0101;
        log_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (log_TVALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL log_exhausted: got %b expected 0", log_TVALID);
            end
            tick();
        end
        din_TVALID = '0;
    endtask

    task automatic test_pause();
        dout_TREADY = '1;
        din_TVALID  = 4'b1000;
        send_cmd(ADDR, 3, 0, 1);
        send_cmd(ADDR, 3, 5, 0);
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (din_TREADY[3] !== 1'b0 || dout_TVALID[3] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pause_hold: got rdy=%b v=%b expected 0 0",
                         din_TREADY[3], dout_TVALID[3]);
            end
            tick();
        end
        send_cmd(ADDR, 3, 0, 0);
        cmd_in_TDATA  = mk_cmd(ADDR, 3, 5, 0);
        cmd_in_TVALID = 1'b1;
        settle();
        checks++;
        if (din_TREADY[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_latch_cycle: got %b expected 0", din_TREADY[3]);
        end
        tick();
        cmd_in_TVALID = 1'b0;
        settle();
        checks++;
        if (din_TREADY[3] !== 1'b1 || dout_TVALID[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_resume: got rdy=%b v=%b expected 1 1",
                     din_TREADY[3], dout_TVALID[3]);
        end
        tick();
        din_TVALID = '0;
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < N; c++) begin
            send_cmd(ADDR, c, 2, 1);
            send_cmd(ADDR, c, 5, 0);
        end
        log_TREADY  = 1'b0;
        dout_TREADY = '1;
        din_TVALID  = '1;
        tick();
        tick();
        settle();
        checks++;
        if (log_TVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_full: got %b expected 1", log_TVALID);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dout_TREADY = 4'b1011;
        settle();
        checks++;
        if (log_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_log: got %b expected 0", log_TVALID);
        end
        checks++;
        if (din_TREADY !== 4'b1011 || dout_TVALID !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL midreset_pass: got rdy=%b v=%b expected 1011 1111",
                     din_TREADY, dout_TVALID);
        end
        tick();
        send_cmd(ADDR, 1, 5, 0);
        settle();
        checks++;
        if (dout_TVALID[1] !== 1'b1 || log_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_shadow: got v=%b log=%b expected 1 0",
                     dout_TVALID[1], log_TVALID);
        end
        tick();
        din_TVALID = '0;
    endtask

    task automatic test_random_traffic();
        logic [LOG_W-1:0] exp_log;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N; c++) din_TDATA[c*DW +: DW] = {$urandom, $urandom};
            din_TKEEP   = 32'($urandom);
            din_TDEST   = {$urandom, $urandom};
            din_TID     = {$urandom, $urandom};
            din_TLAST   = 4'($urandom);
            din_TVALID  = 4'($urandom);
            dout_TREADY = 4'($urandom);
            log_TREADY  = ($urandom_range(0, 3) != 0);
            cmd_in_TVALID = ($urandom_range(0, 5) == 0);
            cmd_in_TDATA  = mk_cmd(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2047)) : ADDR,
                                   int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                                   int'($urandom_range(0, 3)));
            settle();
            checks++;
            if (din_TREADY !== e_rdy || dout_TVALID !== e_dv) begin
                errors++;
                $display("[TB] FAIL rand_fork cyc %0d: got rdy=%b v=%b expected rdy=%b v=%b",
                         cyc, din_TREADY, dout_TVALID, e_rdy, e_dv);
            end
            checks++;
            if (dout_TDATA !== din_TDATA || dout_TKEEP !== din_TKEEP || dout_TLAST !== din_TLAST ||
                dout_TDEST !== din_TDEST || dout_TID !== din_TID) begin
                errors++;
                $display("[TB] FAIL rand_payload cyc %0d: got d0=%h expected d0=%h",
                         cyc, dout_TDATA[63:0], din_TDATA[63:0]);
            end
            checks++;
            if (log_TVALID !== (e_grant >= 0)) begin
                errors++;
                $display("[TB] FAIL rand_log_valid cyc %0d: got %b expected %b",
                         cyc, log_TVALID, e_grant >= 0);
            end else if (e_grant >= 0) begin
                exp_log = {2'(e_grant), lb_keep[e_grant], lb_data[e_grant]};
                checks++;
                if (log_TDATA !== exp_log || log_TLAST !== lb_last[e_grant]) begin
                    errors++;
                    $display("[TB] FAIL rand_log_data cyc %0d: got %h/%b expected %h/%b",
                             cyc, log_TDATA, log_TLAST, exp_log, lb_last[e_grant]);
                end
            end
            checks++;
            if (cmd_out_TVALID !== e_cmd_fwd || (e_cmd_fwd && cmd_out_TDATA !== cmd_in_TDATA)) begin
                errors++;
                $display("[TB] FAIL rand_cmd_out cyc %0d: got v=%b d=%h expected v=%b d=%h",
                         cyc, cmd_out_TVALID, cmd_out_TDATA, e_cmd_fwd, cmd_in_TDATA);
            end
            tick();
        end
        cmd_in_TVALID = 1'b0;
        din_TVALID    = '0;
    endtask

    initial begin
        rst           = 1'b1;
        cmd_in_TDATA  = '0;
        cmd_in_TVALID = 1'b0;
        din_TDATA     = '0;
        din_TKEEP     = '1;
        din_TDEST     = '0;
        din_TID       = '0;
        din_TLAST     = '0;
        din_TVALID    = '0;
        dout_TREADY   = '1;
        log_TREADY    = 1'b0;
        model_reset();

        test_reset();
        test_passthrough();
        test_cmd_forward();
        test_drop_count();
        test_log_rr();
        test_pause();
        test_reset_midflight();
        test_random_traffic();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
